// File: rtl/fb_writer.sv
// fb_writer: crops the VDP pixel stream to the visible window and writes {addr,rgb} words to framebuffer RAM
module fb_writer #(
  parameter int WIN_X0  = 48,
  parameter int WIN_Y0  = 24,
  parameter int WIN_W   = 160,
  parameter int WIN_H   = 144,
  parameter int FIFO_AW = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  pixel_x,
  input  logic [8:0]  pixel_y,
  input  logic [3:0]  color_r,
  input  logic [3:0]  color_g,
  input  logic [3:0]  color_b,
  input  logic        ovf_clr,
  output logic        fb_req,
  output logic [14:0] fb_addr,
  output logic [11:0] fb_data,
  input  logic        fb_ack,
  output logic        frame_start,
  output logic [7:0]  frame_cnt,
  output logic        ovf
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_REQ  = 1'b1;
  logic [17:0]        r_prev_xy;
  logic               r_v;
  logic [14:0]        r_a;
  logic [11:0]        r_d;
  logic [26:0]        r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr, r_rd;
  logic [FIFO_AW:0]   r_count;
  logic               r_ovf, r_frame_start, r_req;
  logic [7:0]         r_frame_cnt;
  logic [14:0]        r_fb_addr;
  logic [11:0]        r_fb_data;
  logic [0:0]         r_state;
  logic               w_new, w_vis, w_full, w_push, w_pop;
  logic [14:0]        w_addr;
  assign w_new  = {pixel_y, pixel_x} != r_prev_xy;
  assign w_vis  = ({1'b0, pixel_x} >= 10'(WIN_X0)) && ({1'b0, pixel_x} < 10'(WIN_X0 + WIN_W)) &&
                  ({1'b0, pixel_y} >= 10'(WIN_Y0)) && ({1'b0, pixel_y} < 10'(WIN_Y0 + WIN_H));
  assign w_addr = (15'(pixel_y) - 15'(WIN_Y0)) * 15'(WIN_W) + 15'(pixel_x) - 15'(WIN_X0);
  assign w_full = r_count == (FIFO_AW+1)'(DEPTH);
  assign w_push = r_v && !w_full;
  assign w_pop  = (r_count != '0) && (r_state == S_IDLE || fb_ack);
  // Detect stage: flag a new visible pixel and precompute its linear address
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_xy <= 18'h3FFFF;
      r_v       <= 1'b0;
      r_a       <= '0;
      r_d       <= '0;
    end else begin
      r_prev_xy <= {pixel_y, pixel_x};
      r_v       <= w_new && w_vis;
      r_a       <= w_addr;
      r_d       <= {color_r, color_g, color_b};
    end
  end
  // FIFO storage, contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {r_a, r_d};
  end
  // FIFO pointers, overflow flag and frame accounting
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr          <= '0;
      r_rd          <= '0;
      r_count       <= '0;
      r_ovf         <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_cnt   <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + FIFO_AW'(1);
      if (w_pop) r_rd <= r_rd + FIFO_AW'(1);
      r_count       <= r_count + (FIFO_AW+1)'(w_push) - (FIFO_AW+1)'(w_pop);
      r_ovf         <= (r_v && w_full) || (r_ovf && !ovf_clr);
      r_frame_start <= w_push && r_a == '0;
      if (w_push && r_a == '0) r_frame_cnt <= r_frame_cnt + 8'd1;
    end
  end
  // Output FSM: pop into the RAM write port, back-to-back while acked words keep coming
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_fb_addr <= '0;
      r_fb_data <= '0;
    end else if (w_pop) begin
      {r_fb_addr, r_fb_data} <= r_mem[r_rd];
      r_req                  <= 1'b1;
      r_state                <= S_REQ;
    end else if (r_state == S_REQ && fb_ack) begin
      r_req   <= 1'b0;
      r_state <= S_IDLE;
    end
  end
  assign fb_req      = r_req;
  assign fb_addr     = r_fb_addr;
  assign fb_data     = r_fb_data;
  assign frame_start = r_frame_start;
  assign frame_cnt   = r_frame_cnt;
  assign ovf         = r_ovf;
endmodule
